// File: rtl/vote_pkg.sv
// Shared types and sizing helpers for the serial vote collector and its idle timer.
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam int TIMEOUT_DEF = 16;
  localparam int TMR_W_DEF   = $clog2(TIMEOUT_DEF);

  // Counter wide enough to hold the full value n, not just n-1.
  function automatic int cntWidth(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int tmrWidth(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/vote_collector_if.sv
// Vote input handshake plus result output handshake of the vote collector.
interface vote_collector_if #(
  parameter int NUM_INPUTS = 5,
  parameter int CNT_W      = 3
);
  logic                  vote_valid;
  logic                  vote_ready;
  logic                  vote_bit;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_INPUTS-1:0] out_vector;
  logic [CNT_W-1:0]      out_count;
  logic                  out_majority;
  logic                  timeout_err;

  modport master (
    output vote_valid, vote_bit, flush, out_ready,
    input  vote_ready, out_valid, out_vector, out_count, out_majority, timeout_err
  );

  modport slave (
    input  vote_valid, vote_bit, flush, out_ready,
    output vote_ready, out_valid, out_vector, out_count, out_majority, timeout_err
  );
endinterface

// File: rtl/vote_idle_timer.sv
// Counts consecutive idle cycles of a partial window; flags the last allowed idle cycle.
module vote_idle_timer
  import vote_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int TMR_W          = tmrWidth(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic terminal_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + TMR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign terminal_o = (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/vote_collector.sv
// Gathers NUM_INPUTS serial votes into a window and presents vector, popcount and
// majority through a one-entry registered output buffer.
module vote_collector
  import vote_pkg::*;
#(
  parameter int NUM_INPUTS     = 5,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int CNT_W          = cntWidth(NUM_INPUTS)
) (
  input  logic clk,
  input  logic rst,
  vote_collector_if.slave bus
);

  state_e                state_q;
  logic [NUM_INPUTS-1:0] vec_q;
  logic [CNT_W-1:0]      n_q;
  logic [CNT_W-1:0]      ones_q;
  logic                  outValid_q;
  logic [NUM_INPUTS-1:0] outVec_q;
  logic [CNT_W-1:0]      outCount_q;
  logic                  outMaj_q;
  logic                  timeoutErr_q;

  logic                  voteReady;
  logic                  accept;
  logic                  timerTerminal;
  logic [NUM_INPUTS-1:0] vec_d;
  logic [CNT_W-1:0]      n_d;
  logic [CNT_W-1:0]      ones_d;

  assign voteReady = (state_q != HOLD) && !bus.flush;
  assign accept    = bus.vote_valid && voteReady;

  // Indexed write keeps the first accepted vote in bit 0; IDLE always starts from a clean vector.
  always_comb begin
    vec_d          = (state_q == IDLE) ? '0 : vec_q;
    vec_d[n_q]     = bus.vote_bit;
    n_d            = n_q + CNT_W'(1);
    ones_d         = ones_q + CNT_W'(bus.vote_bit);
  end

  vote_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   ((state_q != COLLECT) || accept),
    .inc_i     ((state_q == COLLECT) && !accept),
    .terminal_o(timerTerminal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      n_q          <= '0;
      ones_q       <= '0;
      outValid_q   <= 1'b0;
      outVec_q     <= '0;
      outCount_q   <= '0;
      outMaj_q     <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      timeoutErr_q <= 1'b0;
      unique case (state_q)
        IDLE, COLLECT: begin
          if (bus.flush) begin
            state_q <= IDLE;
            vec_q   <= '0;
            n_q     <= '0;
            ones_q  <= '0;
          end else if (accept) begin
            if (n_d == CNT_W'(NUM_INPUTS)) begin
              state_q    <= HOLD;
              outValid_q <= 1'b1;
              outVec_q   <= vec_d;
              outCount_q <= ones_d;
              outMaj_q   <= (ones_d > CNT_W'(NUM_INPUTS >> 1));
              vec_q      <= '0;
              n_q        <= '0;
              ones_q     <= '0;
            end else begin
              state_q <= COLLECT;
              vec_q   <= vec_d;
              n_q     <= n_d;
              ones_q  <= ones_d;
            end
          end else if ((state_q == COLLECT) && timerTerminal) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            n_q          <= '0;
            ones_q       <= '0;
            timeoutErr_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.vote_ready   = voteReady;
  assign bus.out_valid    = outValid_q;
  assign bus.out_vector   = outVec_q;
  assign bus.out_count    = outCount_q;
  assign bus.out_majority = outMaj_q;
  assign bus.timeout_err  = timeoutErr_q;

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector: windows, backpressure, timeout, flush and reset.
module tb_vote_collector;

  localparam int NUM_INPUTS = 5;
  localparam int CNT_W      = 3;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  vote_collector_if #(.NUM_INPUTS(NUM_INPUTS), .CNT_W(CNT_W)) bus ();

  vote_collector #(
    .NUM_INPUTS    (NUM_INPUTS),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic bitVal,
                               input logic flushVal, input logic readyVal);
    bus.vote_valid = valid;
    bus.vote_bit   = bitVal;
    bus.flush      = flushVal;
    bus.out_ready  = readyVal;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic sendVote(input logic b, input logic readyVal);
    applyStimulus(1'b1, b, 1'b0, readyVal);
    tick();
  endtask

  task automatic checkResult(input string tag, input logic [4:0] vec,
                             input logic [2:0] cnt, input logic maj);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_vector"}, 32'(bus.out_vector), 32'(vec));
    checkOutput({tag, "_count"}, 32'(bus.out_count), 32'(cnt));
    checkOutput({tag, "_majority"}, 32'(bus.out_majority), 32'(maj));
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_vector", 32'(bus.out_vector), 32'd0);
    checkOutput("reset_count", 32'(bus.out_count), 32'd0);
    checkOutput("reset_majority", 32'(bus.out_majority), 32'd0);
    checkOutput("reset_timeout", 32'(bus.timeout_err), 32'd0);
    checkOutput("reset_ready", 32'(bus.vote_ready), 32'd1);

    // Full window 1,1,1,0,0 back-to-back with out_ready high.
    sendVote(1'b1, 1'b1);
    sendVote(1'b1, 1'b1);
    sendVote(1'b1, 1'b1);
    sendVote(1'b0, 1'b1);
    checkOutput("full_not_yet", 32'(bus.out_valid), 32'd0);
    sendVote(1'b0, 1'b1);
    checkResult("full", 5'b00111, 3'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("full_hold_ready", 32'(bus.vote_ready), 32'd0);
    tick();
    checkOutput("full_released", 32'(bus.out_valid), 32'd0);
    checkOutput("full_idle_ready", 32'(bus.vote_ready), 32'd1);

    // Minority window 1,0,0,1,0.
    sendVote(1'b1, 1'b1);
    sendVote(1'b0, 1'b1);
    sendVote(1'b0, 1'b1);
    sendVote(1'b1, 1'b1);
    sendVote(1'b0, 1'b1);
    checkResult("minority", 5'b01001, 3'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // All-ones window held under backpressure for 10 cycles.
    for (int i = 0; i < 5; i++) sendVote(1'b1, 1'b0);
    checkResult("allones", 5'b11111, 3'd5, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_ready", 32'(bus.vote_ready), 32'd0);
      checkResult("bp", 5'b11111, 3'd5, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("bp_released", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_next_ready", 32'(bus.vote_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Timeout: two votes then 16 idle cycles.
    sendVote(1'b1, 1'b1);
    sendVote(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("to_early", 32'(bus.timeout_err), 32'd0);
    tick();
    checkOutput("to_pulse", 32'(bus.timeout_err), 32'd1);
    checkOutput("to_idle_ready", 32'(bus.vote_ready), 32'd1);
    tick();
    checkOutput("to_pulse_end", 32'(bus.timeout_err), 32'd0);
    sendVote(1'b0, 1'b1);
    sendVote(1'b1, 1'b1);
    sendVote(1'b0, 1'b1);
    sendVote(1'b1, 1'b1);
    sendVote(1'b1, 1'b1);
    checkResult("to_fresh", 5'b11010, 3'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Accept on the boundary idle cycle wins over the timeout.
    sendVote(1'b1, 1'b1);
    sendVote(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    sendVote(1'b1, 1'b1);
    checkOutput("edge_no_timeout", 32'(bus.timeout_err), 32'd0);
    sendVote(1'b0, 1'b1);
    sendVote(1'b1, 1'b1);
    checkResult("edge", 5'b10101, 3'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Flush with a simultaneous vote at vote 3 drops it and restarts.
    sendVote(1'b1, 1'b1);
    sendVote(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_ready", 32'(bus.vote_ready), 32'd0);
    tick();
    checkOutput("flush_no_timeout", 32'(bus.timeout_err), 32'd0);
    sendVote(1'b0, 1'b0);
    sendVote(1'b0, 1'b0);
    sendVote(1'b1, 1'b0);
    sendVote(1'b0, 1'b0);
    sendVote(1'b0, 1'b0);
    checkResult("flush_restart", 5'b00100, 3'd1, 1'b0);

    // Flush during HOLD must not lose the held result.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checkResult("flush_hold", 5'b00100, 3'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("flush_hold_released", 32'(bus.out_valid), 32'd0);

    // Reset three votes into a window.
    sendVote(1'b1, 1'b1);
    sendVote(1'b1, 1'b1);
    sendVote(1'b1, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_mid_vector", 32'(bus.out_vector), 32'd0);
    checkOutput("rst_mid_count", 32'(bus.out_count), 32'd0);
    checkOutput("rst_mid_timeout", 32'(bus.timeout_err), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("rst_mid_quiet", 32'(bus.timeout_err), 32'd0);
    sendVote(1'b1, 1'b1);
    sendVote(1'b0, 1'b1);
    sendVote(1'b1, 1'b1);
    sendVote(1'b1, 1'b1);
    sendVote(1'b0, 1'b1);
    checkResult("rst_after", 5'b01101, 3'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
